vc_iter_divider: RTL
====================

Name: vc_iter_divider

Overview:
- Iterative restoring integer divider; the inverse counterpart of the team's arithmetic library.
- Produces one quotient bit per cycle behind val/rdy stream interfaces.
- Supports signed and unsigned modes with RISC-V DIV/DIVU/REM/REMU result semantics.
- Sits beside the iterative multiplier in the processor's long-latency execute path.

Parameters:
- p_nbits, 32, operand width in bits; must be ≥ 2.
- Derived internally: counter width = $clog2(p_nbits)+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- istream_val  input  1  request valid.
- istream_rdy  output  1  divider can accept a request.
- istream_msg  input  2*p_nbits+1  {fn_signed, dividend a, divisor b}; fn_signed is the MSB, b the LSBs.
- ostream_val  output  1  result valid.
- ostream_rdy  input  1  consumer can accept the result.
- ostream_msg  output  2*p_nbits  {remainder, quotient}; quotient in the LSBs.

Behaviour:
- Reset is sampled at the clock edge:
  - FSM goes to IDLE; counter, remainder, quotient and sign flags clear to 0.
  - Outputs: istream_rdy=1, ostream_val=0, ostream_msg=0.
  - Reset asserted in any state aborts the operation in flight; no result is emitted.
- State IDLE:
  - istream_rdy=1, ostream_val=0.
  - On istream_val & istream_rdy, latch operands and go to CALC.
  - Latch step, unsigned: |a| = a, |b| = b.
  - Latch step, signed: take two's-complement magnitudes; record sign_q = a[msb]^b[msb] and sign_r = a[msb].
  - Latch step also sets remainder register R=0, quotient/shift register Q=|a|, counter=p_nbits.
  - Divide-by-zero (b==0) is detected here and sets a dz flag.
- State CALC (istream_rdy=0, ostream_val=0), one iteration per cycle:
  - {R,Q} shifted left by 1.
  - If shifted R ≥ |b|: R = R−|b| and Q[0]=1; else Q[0]=0.
  - Compare and subtract use p_nbits+1 bits; no truncation.
  - Counter decrements each cycle; when it reaches 1, the next state is DONE.
  - CALC lasts exactly p_nbits cycles.
- Sign fix-up and special cases (combinational on the output, registered values held):
  - Signed: quotient negated if sign_q; remainder negated if sign_r.
  - Divide-by-zero, both modes: quotient = all ones (−1 signed), remainder = a unchanged. Overrides the sign fix-up.
  - Signed overflow (a = most-negative, b = −1): quotient = a, remainder = 0. This falls out of the magnitude path and must not be special-cased incorrectly.
- State DONE:
  - ostream_val=1 with ostream_msg stable; istream_rdy=0.
  - Holds indefinitely while ostream_rdy=0.
  - On ostream_val & ostream_rdy, go to IDLE.
- Latency and throughput:
  - Accept at edge N; ostream_val first high in cycle N+p_nbits+1.
  - No bypass from DONE to accept; one IDLE cycle between transactions.
  - Maximum throughput: one result per p_nbits+2 cycles.
- ostream_msg is don't-care when ostream_val=0, but holds 0 after reset until the first result.
- No X may propagate to ostream_val or istream_rdy under any input sequence.

Test Plan:
- Unsigned basic: fn=0, a=100, b=7 → quotient=14, remainder=2. ostream_val rises exactly 33 cycles after the accept edge.
- Signed all sign combos:
  - a=−7, b=2 → q=−3, r=−1.
  - a=7, b=−2 → q=−3, r=1.
  - a=−7, b=−2 → q=3, r=−1.
- Divide by zero:
  - fn=1, a=−5, b=0 → q=0xFFFFFFFF, r=0xFFFFFFFB.
  - fn=0, a=9, b=0 → q=0xFFFFFFFF, r=9.
- Overflow and extremes:
  - fn=1, a=0x80000000, b=0xFFFFFFFF → q=0x80000000, r=0.
  - fn=0, a=0xFFFFFFFF, b=1 → q=0xFFFFFFFF, r=0.
- Backpressure and streaming: hold ostream_rdy=0 for 10 cycles in DONE.
  - ostream_msg must stay stable and istream_rdy must stay 0.
  - Then release; send 3 back-to-back requests with istream_val held high.
  - Each is accepted exactly p_nbits+2 cycles apart, and results are in order.
- Reset mid-operation: assert reset at CALC cycle 10 (a=50, b=5).
  - Next cycle: istream_rdy=1, ostream_val=0.
  - A new request a=9, b=3 then returns q=3, r=0 with no stale output.

Source files
------------

// File: rtl/vc_iter_divider.sv
// Iterative restoring integer divider. It produces one quotient bit per
// cycle behind val/rdy streams and returns RISC-V DIV/DIVU/REM/REMU results.
module vc_iter_divider #(
  parameter int p_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   istream_val,
  output logic                   istream_rdy,
  input  logic [2*p_nbits:0]     istream_msg,
  output logic                   ostream_val,
  input  logic                   ostream_rdy,
  output logic [2*p_nbits-1:0]   ostream_msg
);

  localparam int CW = $clog2(p_nbits) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(p_nbits);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [p_nbits-1:0]   r_rem, r_quo, r_divs, r_a;
  logic                 r_sign_q, r_sign_r, r_dz;

  // Request fields and operand magnitudes. In signed mode the most-negative
  // value negates to itself, and that is the correct unsigned magnitude.
  logic                 w_fn;
  logic [p_nbits-1:0]   w_a, w_b, w_a_mag, w_b_mag;
  assign w_fn    = istream_msg[2*p_nbits];
  assign w_a     = istream_msg[2*p_nbits-1:p_nbits];
  assign w_b     = istream_msg[p_nbits-1:0];
  assign w_a_mag = (w_fn && w_a[p_nbits-1]) ? -w_a : w_a;
  assign w_b_mag = (w_fn && w_b[p_nbits-1]) ? -w_b : w_b;

  // One restoring step. The shifted remainder needs p_nbits+1 bits because
  // an unsigned divisor can use the full operand width.
  logic [p_nbits:0]     w_shift, w_diff;
  logic                 w_ge;
  logic [p_nbits-1:0]   w_rem_nxt, w_quo_nxt;
  assign w_shift   = {r_rem, r_quo[p_nbits-1]};
  assign w_diff    = w_shift - {1'b0, r_divs};
  assign w_ge      = (w_shift >= {1'b0, r_divs});
  assign w_rem_nxt = w_ge ? w_diff[p_nbits-1:0] : w_shift[p_nbits-1:0];
  assign w_quo_nxt = {r_quo[p_nbits-2:0], w_ge};

  logic w_acc, w_out_fire;
  assign w_acc      = istream_val && istream_rdy;
  assign w_out_fire = ostream_val && ostream_rdy;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    case (r_state)
      IDLE: begin
        istream_rdy = 1'b1;
        if (w_acc) w_state_nxt = CALC;
      end
      CALC: begin
        if (r_cnt == CNT_ONE) w_state_nxt = DONE;
      end
      DONE: begin
        ostream_val = 1'b1;
        if (w_out_fire) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then iterate once per CALC cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_divs   <= '0;
      r_a      <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
    end else if (r_state == IDLE && w_acc) begin
      r_cnt    <= CNT_INIT;
      r_rem    <= '0;
      r_quo    <= w_a_mag;
      r_divs   <= w_b_mag;
      r_a      <= w_a;
      r_sign_q <= w_fn && (w_a[p_nbits-1] ^ w_b[p_nbits-1]);
      r_sign_r <= w_fn && w_a[p_nbits-1];
      r_dz     <= (w_b == '0);
    end else if (r_state == CALC) begin
      r_cnt    <= r_cnt - CNT_ONE;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
    end
  end

  // Sign fix-up on the held magnitudes. Divide-by-zero takes priority over it.
  logic [p_nbits-1:0] w_q_out, w_r_out;
  always_comb begin
    w_q_out = r_sign_q ? -r_quo : r_quo;
    w_r_out = r_sign_r ? -r_rem : r_rem;
    if (r_dz) begin
      w_q_out = '1;
      w_r_out = r_a;
    end
  end

  assign ostream_msg = {w_r_out, w_q_out};

endmodule
